mux4_rr_arbiter: RTL

- Round-robin arbiter that shares one WIDTH-bit, 4-input mux path between four requesters.
- Grants one owner at a time and holds the grant for the owner's whole transaction.
- Forces preemption after MAX_HOLD cycles when others are waiting.
- Drives the 2-bit select in the same encoding as mux4 (00=A/ch0, 01=B/ch1, 10=C/ch2, 11=D/ch3) and outputs the selected data.

---
 rtl/mux4_rr_arbiter.sv | 71 +++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux path with hold-time preemption
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             preempt
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic [3:0] mask;
    logic [1:0] win;
    logic       hold;
    // candidates are everyone not currently granted; gnt is zero in IDLE so this is the full req there
    always_comb begin
        mask = req & ~gnt;
        win  = ptr;
        for (int i = 3; i >= 0; i--)
            if (mask[2'(ptr + 2'(i))]) win = ptr + 2'(i);
        hold = (state == GRANT) && req[sel] && !((cnt == LAST) && |mask);
    end
    // ownership state: keep the owner, hand over to the rotation winner, or go idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            preempt <= 1'b0;
            if (hold) begin
                if (|mask || cnt != LAST) cnt <= cnt + 8'd1;
            end else if (|mask) begin
                state   <= GRANT;
                busy    <= 1'b1;
                sel     <= win;
                gnt     <= 4'b1 << win;
                cnt     <= '0;
                ptr     <= win + 2'd1;
                preempt <= (state == GRANT) && req[sel];
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
                gnt   <= '0;
                cnt   <= '0;
            end
        end
    end
    // shared mux path driven by the registered select
    always_comb begin
        data_out  = sel[1] ? (sel[0] ? data3 : data2) : (sel[0] ? data1 : data0);
        valid_out = busy & req[sel];
    end
endmodule
